// File: rtl/pipelined_decode_ctrl.sv
// ID-stage decoder with an ID/EX output register, valid/ready handshake,
// load-use interlock, synchronous flush and a saturating stall counter.
module pipelined_decode_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter bit          ENABLE_SHIFTS = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_control,
    output logic             reg_write_enable,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             alu_src_imm,
    output logic             branch_ne,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      d_alu;
    logic            d_rw, d_mr, d_mw, d_br, d_bne, d_src, d_ill;
    logic [4:0]      d_rs1;
    logic [XLEN-1:0] d_imm;
    logic            uses_rs1, uses_rs2, is_shift;
    logic            hazard, accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Shared funct3 -> ALU op map for R-type and I-ALU (base variant).
    function automatic logic [3:0] f3_alu(input logic [2:0] f);
        case (f)
            3'b000:  f3_alu = ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLTU;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    // Combinational decode of the instruction presented by IF/ID.
    always_comb begin
        d_alu    = ALU_ADD;
        d_rw     = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_br     = 1'b0;
        d_bne    = 1'b0;
        d_src    = 1'b0;
        d_ill    = 1'b0;
        d_rs1    = instr[19:15];
        d_imm    = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);
        case (opcode)
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                d_rw     = 1'b1;
                if (funct7 == F7_ZERO)                          d_alu = f3_alu(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)  d_alu = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)  d_alu = ALU_SRA;
                else                                            d_ill = 1'b1;
                if (!ENABLE_SHIFTS && is_shift)                 d_ill = 1'b1;
            end
            OP_I: begin
                uses_rs1 = 1'b1;
                d_rw     = 1'b1;
                d_src    = 1'b1;
                d_imm    = XLEN'($signed(instr[31:20]));
                d_alu    = f3_alu(funct3);
                if (funct3 == 3'b001 && funct7 != F7_ZERO) d_ill = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       d_alu = ALU_SRA;
                    else if (funct7 != F7_ZERO) d_ill = 1'b1;
                end
                if (!ENABLE_SHIFTS && is_shift) d_ill = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1 = 1'b1;
                d_mr     = 1'b1;
                d_rw     = 1'b1;
                d_src    = 1'b1;
                d_imm    = XLEN'($signed(instr[31:20]));
                if (funct3 != 3'b010) d_ill = 1'b1;
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                d_mw     = 1'b1;
                d_src    = 1'b1;
                d_imm    = XLEN'($signed({instr[31:25], instr[11:7]}));
                if (funct3 != 3'b010) d_ill = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                d_br     = 1'b1;
                d_alu    = ALU_SUB;
                d_bne    = funct3[0];
                d_imm    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                if (funct3[2:1] != 2'b00) d_ill = 1'b1;
            end
            OP_LUI: begin
                d_rw  = 1'b1;
                d_src = 1'b1;
                d_rs1 = 5'd0;
                d_imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_alu = ALU_ADD;
            d_rw  = 1'b0;
            d_mr  = 1'b0;
            d_mw  = 1'b0;
            d_br  = 1'b0;
            d_bne = 1'b0;
            d_src = 1'b0;
            d_imm = '0;
        end
        if (instr[11:7] == 5'd0) d_rw = 1'b0;
    end

    // Load-use interlock against the load sitting in ID/EX, and accept logic.
    assign hazard = out_valid && mem_read && (rd != 5'd0) &&
                    ((uses_rs1 && (instr[19:15] == rd)) || (uses_rs2 && (instr[24:20] == rd)));
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ID/EX register: flush > accept > drain-to-bubble > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            alu_control      <= '0;
            reg_write_enable <= 1'b0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            branch           <= 1'b0;
            alu_src_imm      <= 1'b0;
            branch_ne        <= 1'b0;
            rs1              <= '0;
            rs2              <= '0;
            rd               <= '0;
            imm              <= '0;
            pc_out           <= '0;
            illegal          <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            alu_control      <= d_alu;
            reg_write_enable <= d_rw;
            mem_read         <= d_mr;
            mem_write        <= d_mw;
            branch           <= d_br;
            alu_src_imm      <= d_src;
            branch_ne        <= d_bne;
            rs1              <= d_rs1;
            rs2              <= instr[24:20];
            rd               <= instr[11:7];
            imm              <= d_imm;
            pc_out           <= pc_in;
            illegal          <= d_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles an instruction waited on the interlock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
module tb_pipelined_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] instr, pc_in;

    logic        in_ready, out_valid, reg_write_enable, mem_read, mem_write;
    logic        branch, alu_src_imm, branch_ne, illegal;
    logic [3:0]  alu_control;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc_out;
    logic [15:0] stall_cnt;

    logic        ns_in_ready, ns_out_valid, ns_rw, ns_mr, ns_mw, ns_br, ns_src, ns_bne, ns_ill;
    logic [3:0]  ns_alu;
    logic [4:0]  ns_rs1, ns_rs2, ns_rd;
    logic [31:0] ns_imm, ns_pc_out;
    logic [2:0]  ns_stall_cnt;

    always #5 clk = ~clk;

    pipelined_decode_ctrl #(.XLEN(32), .ENABLE_SHIFTS(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_control(alu_control),
        .reg_write_enable(reg_write_enable), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .alu_src_imm(alu_src_imm),
        .branch_ne(branch_ne), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .pc_out(pc_out), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    // Shift-less variant with a narrow counter, driven in lockstep.
    pipelined_decode_ctrl #(.XLEN(32), .ENABLE_SHIFTS(1'b0), .CNT_W(3)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready),
        .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(ns_out_valid),
        .out_ready(out_ready), .alu_control(ns_alu),
        .reg_write_enable(ns_rw), .mem_read(ns_mr),
        .mem_write(ns_mw), .branch(ns_br), .alu_src_imm(ns_src),
        .branch_ne(ns_bne), .rs1(ns_rs1), .rs2(ns_rs2), .rd(ns_rd), .imm(ns_imm),
        .pc_out(ns_pc_out), .illegal(ns_ill), .stall_cnt(ns_stall_cnt)
    );

    typedef struct packed {
        logic [25:0] ctrl;
        logic [31:0] imm;
        logic        ic;
        logic [31:0] pc;
    } sb_t;

    // Flag groups {rw, mr, mw, br, bne, src, ill}.
    localparam logic [6:0] F_R   = 7'b1000000;
    localparam logic [6:0] F_I   = 7'b1000010;
    localparam logic [6:0] F_LD  = 7'b1100010;
    localparam logic [6:0] F_LD0 = 7'b0100010;
    localparam logic [6:0] F_ST  = 7'b0010010;
    localparam logic [6:0] F_BEQ = 7'b0001000;
    localparam logic [6:0] F_BNE = 7'b0001100;
    localparam logic [6:0] F_ILL = 7'b0000001;
    localparam logic [6:0] F_NO  = 7'b0000000;

    sb_t         sb[$];
    sb_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] next_pc;

    function automatic sb_t mk(input logic [3:0] alu, input logic [6:0] fl, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] d, input logic [31:0] im,
                               input logic ic);
        sb_t t;
        t.ctrl = {alu, fl, r1, r2, d};
        t.imm  = im;
        t.ic   = ic;
        t.pc   = '0;
        return t;
    endfunction

    function automatic logic [25:0] dut_ctrl();
        return {alu_control, reg_write_enable, mem_read, mem_write, branch, branch_ne,
                alu_src_imm, illegal, rs1, rs2, rd};
    endfunction

    function automatic logic [25:0] ns_ctrl();
        return {ns_alu, ns_rw, ns_mr, ns_mw, ns_br, ns_bne, ns_src, ns_ill, ns_rs1, ns_rs2, ns_rd};
    endfunction

    // Scoreboard: every EX handshake must match the oldest accepted instruction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got ctrl=%h pc=%h", dut_ctrl(), pc_out);
            end else begin
                mon_e = sb.pop_front();
                if (dut_ctrl() !== mon_e.ctrl || pc_out !== mon_e.pc ||
                    (mon_e.ic && imm !== mon_e.imm)) begin
                    errors++;
                    $display("FAIL sb_out got ctrl=%h imm=%h pc=%h exp ctrl=%h imm=%h pc=%h",
                             dut_ctrl(), imm, pc_out, mon_e.ctrl, mon_e.imm, mon_e.pc);
                end
            end
        end
    end

    task automatic send(input logic [31:0] i, input sb_t e, output int waits);
        sb_t t;
        t = e;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = i;
        pc_in    = next_pc;
        #1;
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout instr=%h waits=%0d", i, waits);
        end else begin
            t.pc = next_pc;
            sb.push_back(t);
        end
        next_pc = next_pc + 32'd4;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        instr    = '0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; pc_in = '0; next_pc = 32'h100;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, dut_ctrl(), imm, pc_out, stall_cnt} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got out_valid=%b ctrl=%h imm=%h pc=%h stall=%0d in_ready=%b required zeros, in_ready=1",
                     out_valid, dut_ctrl(), imm, pc_out, stall_cnt, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] ins [9];
        sb_t         ex  [9];
        int          w, tot;
        send(32'h002081B3, mk(4'd0, F_R, 5'd1, 5'd2, 5'd3, '0, 1'b0), w);
        idle();
        checks++;
        if (out_valid !== 1'b1 || rd !== 5'd3 || alu_control !== 4'd0) begin
            errors++;
            $display("FAIL add_latency got out_valid=%b rd=%0d alu=%h required 1/3/0", out_valid, rd, alu_control);
        end
        drain();
        ins[0] = 32'h40628233; ex[0] = mk(4'd1, F_R,   5'd5, 5'd6, 5'd4,  '0, 1'b0);
        ins[1] = 32'h0020F3B3; ex[1] = mk(4'd2, F_R,   5'd1, 5'd2, 5'd7,  '0, 1'b0);
        ins[2] = 32'h0020C433; ex[2] = mk(4'd4, F_R,   5'd1, 5'd2, 5'd8,  '0, 1'b0);
        ins[3] = 32'h00208033; ex[3] = mk(4'd0, F_NO,  5'd1, 5'd2, 5'd0,  '0, 1'b0);
        ins[4] = 32'h4020F3B3; ex[4] = mk(4'd0, F_ILL, 5'd1, 5'd2, 5'd7,  '0, 1'b0);
        ins[5] = 32'h0000007F; ex[5] = mk(4'd0, F_ILL, 5'd0, 5'd0, 5'd0,  '0, 1'b0);
        ins[6] = 32'h00209463; ex[6] = mk(4'd1, F_BNE, 5'd1, 5'd2, 5'd8,  32'd8, 1'b1);
        ins[7] = 32'h0020A623; ex[7] = mk(4'd0, F_ST,  5'd1, 5'd2, 5'd12, 32'd12, 1'b1);
        ins[8] = 32'h12345637; ex[8] = mk(4'd0, F_I,   5'd0, 5'd3, 5'd12, 32'h12345000, 1'b1);
        tot = 0;
        for (int k = 0; k < 9; k++) begin
            send(ins[k], ex[k], w);
            tot += w;
        end
        idle();
        checks++;
        if (tot !== 0) begin
            errors++;
            $display("FAIL back_to_back got stall_cycles=%0d required 0", tot);
        end
        drain();
    endtask

    task automatic test_load_use();
        int w;
        int s0;
        s0 = int'(stall_cnt);
        send(32'h0080A283, mk(4'd0, F_LD, 5'd1, 5'd8, 5'd5, 32'd8, 1'b1), w);
        send(32'h00228333, mk(4'd0, F_R,  5'd5, 5'd2, 5'd6, '0, 1'b0), w);
        idle();
        checks++;
        if (w !== 1 || int'(stall_cnt) - s0 !== 1) begin
            errors++;
            $display("FAIL load_use got held=%0d stall_delta=%0d required 1/1", w, int'(stall_cnt) - s0);
        end
        drain();
    endtask

    task automatic test_load_x0();
        int w;
        int s0;
        s0 = int'(stall_cnt);
        send(32'h0000A003, mk(4'd0, F_LD0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1), w);
        send(32'h00200333, mk(4'd0, F_R,   5'd0, 5'd2, 5'd6, '0, 1'b0), w);
        idle();
        checks++;
        if (w !== 0 || int'(stall_cnt) !== s0) begin
            errors++;
            $display("FAIL load_x0 got held=%0d stall=%0d required 0/%0d", w, stall_cnt, s0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int          w;
        sb_t         sub_e, addi_e;
        logic [31:0] sub_pc;
        sub_e  = mk(4'd1, F_R, 5'd5, 5'd6, 5'd4, '0, 1'b0);
        addi_e = mk(4'd0, F_I, 5'd1, 5'd31, 5'd9, 32'hFFFFFFFF, 1'b1);
        set_ready(1'b0);
        sub_pc = next_pc;
        send(32'h40628233, sub_e, w);
        @(negedge clk);
        instr = 32'hFFF08493;
        pc_in = next_pc;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_ctrl() !== sub_e.ctrl || pc_out !== sub_pc) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got in_ready=%b out_valid=%b ctrl=%h pc=%h required 0/1/%h/%h",
                         k, in_ready, out_valid, dut_ctrl(), pc_out, sub_e.ctrl, sub_pc);
            end
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise got in_ready=%b required 1", in_ready);
        end else begin
            addi_e.pc = next_pc;
            sb.push_back(addi_e);
        end
        next_pc = next_pc + 32'd4;
        @(posedge clk);
        idle();
        drain();
    endtask

    task automatic test_flush();
        int  w;
        sb_t dropped;
        set_ready(1'b0);
        send(32'h002081B3, mk(4'd0, F_R, 5'd1, 5'd2, 5'd3, '0, 1'b0), w);
        @(negedge clk);
        instr = 32'h00209463;
        pc_in = next_pc;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got out_valid=%b required 0", out_valid);
        end
        if (sb.size() != 0) dropped = sb.pop_back();
        next_pc = next_pc + 32'd4;
        set_ready(1'b1);
        send(32'hFE208EE3, mk(4'd1, F_BEQ, 5'd1, 5'd2, 5'd29, 32'hFFFFFFFC, 1'b1), w);
        idle();
        drain();
    endtask

    task automatic test_shifts();
        int w;
        send(32'h40315093, mk(4'd9, F_I, 5'd2, 5'd3, 5'd1, 32'h00000403, 1'b1), w);
        idle();
        checks++;
        if (ns_out_valid !== 1'b1 || ns_ctrl() !== mk(4'd0, F_ILL, 5'd2, 5'd3, 5'd1, '0, 1'b0).ctrl) begin
            errors++;
            $display("FAIL srai_noshift got valid=%b ctrl=%h required 1/%h", ns_out_valid, ns_ctrl(),
                     mk(4'd0, F_ILL, 5'd2, 5'd3, 5'd1, '0, 1'b0).ctrl);
        end
        send(32'h0020B5B3, mk(4'd6, F_R, 5'd1, 5'd2, 5'd11, '0, 1'b0), w);
        idle();
        checks++;
        if (ns_ill !== 1'b1 || ns_rw !== 1'b0 || ns_alu !== 4'd0) begin
            errors++;
            $display("FAIL sltu_noshift got ill=%b rw=%b alu=%h required 1/0/0", ns_ill, ns_rw, ns_alu);
        end
        send(32'h00209533, mk(4'd7, F_R,   5'd1, 5'd2, 5'd10, '0, 1'b0), w);
        send(32'h40311093, mk(4'd0, F_ILL, 5'd2, 5'd3, 5'd1,  '0, 1'b0), w);
        idle();
        drain();
    endtask

    task automatic test_stall_saturate();
        int w;
        int s0;
        s0 = int'(stall_cnt);
        set_ready(1'b0);
        send(32'h0080A283, mk(4'd0, F_LD, 5'd1, 5'd8, 5'd5, 32'd8, 1'b1), w);
        fork
            send(32'h00228333, mk(4'd0, F_R, 5'd5, 5'd2, 5'd6, '0, 1'b0), w);
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        checks++;
        if (w !== 11 || int'(stall_cnt) - s0 !== 11) begin
            errors++;
            $display("FAIL stall_count got held=%0d delta=%0d required 11/11", w, int'(stall_cnt) - s0);
        end
        checks++;
        if (ns_stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL stall_saturate got %0d required 7", ns_stall_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_use();
        test_load_x0();
        test_backpressure();
        test_flush();
        test_shifts();
        test_stall_saturate();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_decode_ctrl.md
Name: pipelined_decode_ctrl

Overview:
ID-stage decode/control unit with an ID/EX output register. It extends the combinational ALU/write-enable decoder with load/store/branch/LUI decode, immediate generation, optional shift ops and illegal-instruction flagging. It also adds a valid/ready handshake, a load-use interlock (bubble insertion), synchronous flush and a saturating stall counter. It sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, datapath width of pc and imm (32 or 64); imm is sign-extended to XLEN.
ENABLE_SHIFTS, 1, 1 = decode SLL/SRL/SRA/SLTU (and SLLI/SRLI/SRAI); 0 = those encodings flag illegal.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  instruction accepted this cycle when in_valid&in_ready
instr  in  32  instruction word
pc_in  in  XLEN  instruction pc
flush  in  1  branch-taken kill (synchronous)
out_valid  out  1  ID/EX register holds a live instruction
out_ready  in  1  EX accepts when out_valid&out_ready
alu_control  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001
reg_write_enable  out  1  writeback enable
mem_read, mem_write, branch, alu_src_imm  out  1 each  control bits
branch_ne  out  1  1 = BNE, 0 = BEQ
rs1, rs2, rd  out  5 each  register indices
imm  out  XLEN  sign-extended immediate
pc_out  out  XLEN  registered pc
illegal  out  1  unsupported encoding
stall_cnt  out  CNT_W  saturating count of interlock cycles

Behaviour:
- Reset (rst_n low, async): out_valid=0; all control outputs, rs*, rd, imm, pc_out and stall_cnt = 0. in_ready is a function of state, so it is 1 out of reset.
- Decode is combinational on instr and is registered on accept. Latency is 1 cycle from accept to out_valid.
- R-type (0110011): reg_write=1. Accepted funct7 values:
  - 0000000 for any listed funct3.
  - 0100000 only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7/funct3 combination -> illegal.
  - funct3 map: 000 ADD/SUB, 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL, 101 SRL/SRA.
- I-ALU (0010011): reg_write=1, alu_src_imm=1, imm=sext(instr[31:20]). Same funct3 map; 011 = SLTU.
  - 001 requires instr[31:25]=0.
  - 101 selects SRA when instr[30]=1 (instr[31:25]=0100000) and SRL when instr[31:25]=0; other values -> illegal.
- LOAD (0000011, funct3 010 only): mem_read=1, reg_write=1, alu_src_imm=1, ADD, I-imm.
- STORE (0100011, funct3 010 only): mem_write=1, alu_src_imm=1, ADD, imm=sext({instr[31:25],instr[11:7]}), reg_write=0.
- BRANCH (1100011, funct3 000/001): branch=1, SUB, branch_ne=funct3[0], imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- LUI (0110111): reg_write=1, alu_src_imm=1, ADD, rs1 forced 0, imm=sext({instr[31:12],12'b0}).
- ENABLE_SHIFTS=0: SLL/SRL/SRA/SLTU encodings (R and I) -> illegal.
- Illegal or unknown opcode: illegal=1, reg_write/mem_read/mem_write/branch=0, alu_control=0000. The instruction still propagates with out_valid=1.
- rd==0: reg_write_enable forced 0.
- Hazard (combinational) = out_valid & mem_read(reg) & rd(reg)!=0 & ((uses_rs1 & instr.rs1==rd(reg)) | (uses_rs2 & instr.rs2==rd(reg))).
  - uses_rs1: R, I-ALU, LOAD, STORE, BRANCH.
  - uses_rs2: R, STORE, BRANCH.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Register update priority:
  1. flush: out_valid<=0; the instruction presented this cycle is dropped.
  2. Accept: load decoded fields, out_valid<=1.
  3. Output handshake without accept: out_valid<=0 (bubble).
  4. Otherwise hold all outputs stable (out_ready low).
- stall_cnt increments by 1 each cycle in_valid&hazard&!flush, and saturates at all-ones.
- Flush and reset mid-handshake: no partial state. Outputs hold their values while out_valid=0, but are don't-care.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, alu_control=0000, reg_write=1, rd=3, rs1=1, rs2=2.
- LW x5,8(x1) then ADD x6,x5,x2 back-to-back -> ADD held one cycle (in_ready=0), one out_valid=0 bubble, ADD issues next; stall_cnt=1.
- LW x0,0(x1) then ADD x6,x0,x2 -> no stall; LW reg_write=0.
- out_ready=0 for 3 cycles with SUB registered -> outputs stable, in_ready=0; ADDI accepted the cycle out_ready rises.
- flush asserted while in_valid=1 with BNE -> out_valid=0 next cycle, BNE dropped; the following instruction decodes normally.
- ENABLE_SHIFTS=0, SRAI x1,x2,3 (0x40315093) -> illegal=1, reg_write=0. ENABLE_SHIFTS=1 -> alu_control=1001, imm low bits 0x403. BEQ with imm -4 -> imm=0xFFFFFFFC, branch_ne=0.
